// File: rtl/stretch_pkg.sv
// Shared definitions for the multi-channel pulse stretcher.
//   - mode encodings driven on stretch_mc.mode
//   - per-channel FSM state encoding used inside stretch_chan
package stretch_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RETRIG  = 2'b01;
  localparam logic [1:0] MODE_QUEUE   = 2'b10;
  // 2'b11 is reserved and handled exactly like MODE_ONESHOT.

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_GAP  = 2'b10
  } chan_state_e;

endpackage

// File: rtl/stretch_chan.sv
// One pulse-stretcher channel.
//   c     clock
//   rn    asynchronous active-low reset
//   n     input event (every high cycle is one event)
//   len   output width in clocks, sampled when a pulse (re)starts; 0 acts as 1
//   mode  one-shot / retrigger / queued behaviour for events that hit a busy channel
//   clr   synchronous clear of the sticky overflow flag
//   w     stretched output, registered
//   ovf   sticky flag: an event was dropped
module stretch_chan
  import stretch_pkg::*;
#(
  parameter int LW = 8,
  parameter int QW = 3
) (
  input  logic          c,
  input  logic          rn,
  input  logic          n,
  input  logic [LW-1:0] len,
  input  logic [1:0]    mode,
  input  logic          clr,
  output logic          w,
  output logic          ovf
);

  localparam logic [QW-1:0] PEND_MAX = '1;

  chan_state_e   st_q, st_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] pend_q, pend_d;
  logic          w_q, w_d;
  logic          ovf_q, ovf_d;

  logic [LW-1:0] load;
  logic          drop;

  // Counter holds "cycles left after this one", so a width of L loads L-1.
  assign load = (len == '0) ? '0 : len - LW'(1);

  always_comb begin
    // NOTE: every _d value gets a default before the case so no latch is inferred.
    st_d   = st_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    w_d    = w_q;
    drop   = 1'b0;

    unique case (st_q)
      S_IDLE: begin
        if (n) begin
          cnt_d = load;
          w_d   = 1'b1;
          st_d  = S_HIGH;
        end
      end

      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
        end else begin
          // Expiry: an event in this same cycle still counts as pending in
          // queued mode, so it is part of the GAP decision.
          w_d = 1'b0;
          if (mode == MODE_QUEUE && (pend_q != '0 || n)) begin
            st_d = S_GAP;
          end else begin
            st_d   = S_IDLE;
            pend_d = '0;
          end
        end

        if (n) begin
          case (mode)
            MODE_RETRIG: begin
              cnt_d = load;
              w_d   = 1'b1;
              st_d  = S_HIGH;
            end
            MODE_QUEUE: begin
              if (pend_q == PEND_MAX) drop = 1'b1;
              else                    pend_d = pend_q + QW'(1);
            end
            default: drop = 1'b1;
          endcase
        end
      end

      S_GAP: begin
        // One forced low cycle, then serve the next queued pulse.
        pend_d = pend_q - QW'(1);
        cnt_d  = load;
        w_d    = 1'b1;
        st_d   = S_HIGH;

        if (n) begin
          case (mode)
            MODE_RETRIG: ;  // already reloading from len this cycle
            MODE_QUEUE: begin
              // Arrival and consumption in the same cycle cancel out.
              if (pend_q == PEND_MAX) drop = 1'b1;
              else                    pend_d = pend_q;
            end
            default: drop = 1'b1;
          endcase
        end
      end

      default: begin
        st_d   = S_IDLE;
        w_d    = 1'b0;
        pend_d = '0;
      end
    endcase

    // A drop in the same cycle as clr wins, keeping the flag set.
    ovf_d = drop ? 1'b1 : (clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      pend_q <= '0;
      w_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      w_q    <= w_d;
      ovf_q  <= ovf_d;
    end
  end

  assign w   = w_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/stretch_mc.sv
// Multi-channel pulse stretcher: CH independent stretch_chan instances
// sharing len, mode and clr.
//   c     clock (48 MHz nominal)
//   rn    asynchronous active-low reset
//   n     per-channel input strobes
//   len   stretched width in clocks (0 treated as 1)
//   mode  00 one-shot, 01 retrigger, 10 queued, 11 as one-shot
//   clr   synchronous clear of all ovf flags
//   w     per-channel stretched outputs, registered
//   ovf   per-channel sticky dropped-event flags
module stretch_mc
  import stretch_pkg::*;
#(
  parameter int CH = 4,
  parameter int LW = 8,
  parameter int QW = 3
) (
  input  logic          c,
  input  logic          rn,
  input  logic [CH-1:0] n,
  input  logic [LW-1:0] len,
  input  logic [1:0]    mode,
  input  logic          clr,
  output logic [CH-1:0] w,
  output logic [CH-1:0] ovf
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    stretch_chan #(
      .LW (LW),
      .QW (QW)
    ) u_chan (
      .c    (c),
      .rn   (rn),
      .n    (n[i]),
      .len  (len),
      .mode (mode),
      .clr  (clr),
      .w    (w[i]),
      .ovf  (ovf[i])
    );
  end

endmodule

// File: tb/tb_stretch_mc.sv
// Bench for stretch_mc. Each stimulus cycle drives the inputs and pushes the
// hand-derived expected outputs for that cycle; a monitor on the falling edge
// pops and compares whatever is queued.
module tb_stretch_mc;

  logic       c = 1'b0;
  logic       rn = 1'b0;
  logic [3:0] n = '0;
  logic [7:0] len = '0;
  logic [1:0] mode = '0;
  logic       clr = 1'b0;
  logic [3:0] w;
  logic [3:0] ovf;

  stretch_mc #(.CH(4), .LW(8), .QW(3)) dut (
    .c    (c),
    .rn   (rn),
    .n    (n),
    .len  (len),
    .mode (mode),
    .clr  (clr),
    .w    (w),
    .ovf  (ovf)
  );

  always #5 c = ~c;

  typedef struct {
    string      nm;
    int         t;
    logic [3:0] w;
    logic [3:0] ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Inputs for cycle t are applied just after the rising edge that opens it;
  // the expectation describes the outputs visible during that same cycle.
  task automatic cyc(input int t, input logic [3:0] nv, input logic [7:0] lv,
                     input logic [1:0] md, input logic cv, input logic rv,
                     input logic [3:0] ew, input logic [3:0] eo, input string nm);
    exp_t e;
    @(posedge c);
    #1;
    n    = nv;
    len  = lv;
    mode = md;
    clr  = cv;
    rn   = rv;
    e.nm = nm; e.t = t; e.w = ew; e.ovf = eo;
    sb.push_back(e);
  endtask

  function automatic logic b(input int t, input int a, input int z);
    return (t >= a) && (t <= z);
  endfunction

  always @(negedge c) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (w !== e.w || ovf !== e.ovf) begin
        miscompares++;
        $display("FAIL %s t=%0d: got w=%b ovf=%b, expected w=%b ovf=%b",
                 e.nm, e.t, w, ovf, e.w, e.ovf);
      end
    end
  end

  initial begin
    logic [1:0] md;
    logic [3:0] nv;
    logic [7:0] lv;
    int         k;

    // Reset held with all inputs asserted: nothing may come out.
    for (int t = 0; t < 3; t++)
      cyc(t, 4'hF, 8'd32, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, "reset_hold");

    // First pulse after release, len=32: high on cycles 1..32.
    for (int t = 0; t <= 34; t++)
      cyc(t, {3'b0, t == 0}, 8'd32, 2'b00, 1'b0, 1'b1,
          {3'b0, b(t, 1, 32)}, 4'h0, "reset_len32");

    // One-shot: second pulse at t=5 is dropped; clr at t=12.
    for (int t = 0; t <= 14; t++)
      cyc(t, {3'b0, t == 0 || t == 5}, 8'd10, 2'b00, t == 12, 1'b1,
          {3'b0, b(t, 1, 10)}, {3'b0, b(t, 6, 12)}, "oneshot");

    // Retrigger at 0,5,9 with len=10: continuously high 1..19.
    for (int t = 0; t <= 21; t++)
      cyc(t, {3'b0, t == 0 || t == 5 || t == 9}, 8'd10, 2'b01, 1'b0, 1'b1,
          {3'b0, b(t, 1, 19)}, 4'h0, "retrig");

    // Queued: 9 strobes t=0..8 all land inside the first 10-clock pulse, so
    // the 7-deep pending count fills at t=7 and the t=8 strobe is dropped.
    // Eight pulses result, each 10 high then 1 low: high on 1+11j..10+11j.
    for (int t = 0; t <= 92; t++)
      cyc(t, {3'b0, t <= 8}, 8'd10, 2'b10, t == 90, 1'b1,
          {3'b0, (t >= 1 && t <= 87 && ((t - 1) % 11) < 10)},
          {3'b0, b(t, 9, 90)}, "queue");

    // len=0 gives a single-clock output.
    for (int t = 0; t <= 3; t++)
      cyc(t, {3'b0, t == 0}, 8'd0, 2'b00, 1'b0, 1'b1,
          {3'b0, t == 1}, 4'h0, "len0");

    // len=255 gives the maximum width.
    for (int t = 0; t <= 257; t++)
      cyc(t, {3'b0, t == 0}, 8'd255, 2'b00, 1'b0, 1'b1,
          {3'b0, b(t, 1, 255)}, 4'h0, "len255");

    // Event on the expiry cycle (len=3: expiry at t=3), one-shot and reserved.
    for (int m = 0; m < 2; m++) begin
      md = (m == 0) ? 2'b00 : 2'b11;
      for (int t = 0; t <= 7; t++)
        cyc(t, {3'b0, t == 0 || t == 3}, 8'd3, md, t == 6, 1'b1,
            {3'b0, b(t, 1, 3)}, {3'b0, b(t, 4, 6)}, "expiry_oneshot");
    end

    // Expiry event in retrigger: reload with no gap, high 1..6.
    for (int t = 0; t <= 8; t++)
      cyc(t, {3'b0, t == 0 || t == 3}, 8'd3, 2'b01, 1'b0, 1'b1,
          {3'b0, b(t, 1, 6)}, 4'h0, "expiry_retrig");

    // Expiry event in queued: gap at 4, second pulse 5..7.
    for (int t = 0; t <= 9; t++)
      cyc(t, {3'b0, t == 0 || t == 3}, 8'd3, 2'b10, 1'b0, 1'b1,
          {3'b0, b(t, 1, 3) || b(t, 5, 7)}, 4'h0, "expiry_queue");

    // clr coinciding with a drop: the set wins; plain clr at t=8 clears.
    for (int t = 0; t <= 9; t++)
      cyc(t, {3'b0, t == 0 || t == 2}, 8'd5, 2'b00, t == 2 || t == 8, 1'b1,
          {3'b0, b(t, 1, 5)}, {3'b0, b(t, 3, 8)}, "clr_vs_set");

    // Independent channels with different len sampled at each pulse start.
    for (int t = 0; t <= 13; t++) begin
      nv = {t == 4, t == 2, t == 1, t == 0};
      case (t)
        0:       lv = 8'd3;
        1:       lv = 8'd5;
        2:       lv = 8'd2;
        4:       lv = 8'd7;
        default: lv = 8'd9;
      endcase
      cyc(t, nv, lv, 2'b00, 1'b0, 1'b1,
          {b(t, 5, 11), b(t, 3, 4), b(t, 2, 6), b(t, 1, 3)}, 4'h0, "indep");
    end

    // Reset in the middle of queued pulses on channels 0 and 2.
    for (int t = 0; t <= 14; t++)
      cyc(t, (t <= 2) ? 4'b0101 : 4'b0000, 8'd6, 2'b10, 1'b0,
          !(t == 4 || t == 5), b(t, 1, 3) ? 4'b0101 : 4'b0000, 4'h0, "reset_mid");

    // Let the monitor drain the queue, with a bounded wait.
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge c);
      k++;
    end
    @(posedge c);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
